// File: rtl/axi_llc_evict_sequencer_pkg.sv
// axi_llc_evict_sequencer_pkg: FSM state enum, transaction descriptor struct and default widths for the eviction sequencer.
package axi_llc_evict_sequencer_pkg;
    localparam int unsigned SA_DEF  = 8;
    localparam int unsigned IL_DEF  = 8;
    localparam int unsigned TL_DEF  = 20;
    localparam int unsigned PCW_DEF = 32;
    typedef enum logic [2:0] {IDLE, HIT_UPD, EV_WAIT, WB_REQ, RF_REQ, RSP} evict_seq_state_e;
    typedef struct packed {
        logic [IL_DEF-1:0]        index;
        logic [TL_DEF-1:0]        tag;
        logic [SA_DEF*TL_DEF-1:0] old_tags;
        logic [SA_DEF-1:0]        way;
        logic                     hit;
    } evict_seq_desc_t;
endpackage

// File: rtl/axi_llc_evict_sequencer_if.sv
// axi_llc_evict_sequencer_if: lookup, eviction-box, write-back, refill, response and perf signals; master = sequencer side, slave = environment side.
interface axi_llc_evict_sequencer_if #(
    parameter int unsigned SetAssociativity = 8,
    parameter int unsigned IndexLength      = 8,
    parameter int unsigned TagLength        = 20,
    parameter int unsigned PerfCntWidth     = 32
);
    logic                                 lu_valid_i, lu_ready_o, lu_hit_i;
    logic [SetAssociativity-1:0]          lu_hit_way_i;
    logic [IndexLength-1:0]               lu_index_i;
    logic [TagLength-1:0]                 lu_tag_i;
    logic [SetAssociativity*TagLength-1:0] lu_old_tag_i;
    logic                                 evict_o, hit_o;
    logic [SetAssociativity-1:0]          res_ind_o;
    logic [IndexLength-1:0]               index_o;
    logic [SetAssociativity-1:0]          box_way_i;
    logic                                 box_evict_i, box_valid_i, box_plru_vld_i;
    logic                                 wb_valid_o, wb_ready_i;
    logic [IndexLength-1:0]               wb_index_o;
    logic [TagLength-1:0]                 wb_tag_o;
    logic [SetAssociativity-1:0]          wb_way_o;
    logic                                 rf_valid_o, rf_ready_i;
    logic [IndexLength-1:0]               rf_index_o;
    logic [TagLength-1:0]                 rf_tag_o;
    logic [SetAssociativity-1:0]          rf_way_o;
    logic                                 rsp_valid_o, rsp_ready_i, rsp_hit_o;
    logic [SetAssociativity-1:0]          rsp_way_o;
    logic [PerfCntWidth-1:0]              perf_hit_o, perf_miss_o, perf_wb_o;
    modport master (
        input  lu_valid_i, lu_hit_i, lu_hit_way_i, lu_index_i, lu_tag_i, lu_old_tag_i,
        input  box_way_i, box_evict_i, box_valid_i, box_plru_vld_i, wb_ready_i, rf_ready_i, rsp_ready_i,
        output lu_ready_o, evict_o, hit_o, res_ind_o, index_o,
        output wb_valid_o, wb_index_o, wb_tag_o, wb_way_o, rf_valid_o, rf_index_o, rf_tag_o, rf_way_o,
        output rsp_valid_o, rsp_hit_o, rsp_way_o, perf_hit_o, perf_miss_o, perf_wb_o
    );
    modport slave (
        output lu_valid_i, lu_hit_i, lu_hit_way_i, lu_index_i, lu_tag_i, lu_old_tag_i,
        output box_way_i, box_evict_i, box_valid_i, box_plru_vld_i, wb_ready_i, rf_ready_i, rsp_ready_i,
        input  lu_ready_o, evict_o, hit_o, res_ind_o, index_o,
        input  wb_valid_o, wb_index_o, wb_tag_o, wb_way_o, rf_valid_o, rf_index_o, rf_tag_o, rf_way_o,
        input  rsp_valid_o, rsp_hit_o, rsp_way_o, perf_hit_o, perf_miss_o, perf_wb_o
    );
endinterface

// File: rtl/axi_llc_evict_seq_perf.sv
// axi_llc_evict_seq_perf: three saturating event counters (hit, miss, write-back); ports clk_i, rst_i, inc_*_i strobes, *_o counts.
module axi_llc_evict_seq_perf #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_hit_i,
    input  logic             inc_miss_i,
    input  logic             inc_wb_i,
    output logic [Width-1:0] hit_o,
    output logic [Width-1:0] miss_o,
    output logic [Width-1:0] wb_o
);
    logic [2:0]       inc;
    logic [Width-1:0] cnt_q [3];
    assign inc = {inc_wb_i, inc_miss_i, inc_hit_i};
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (inc[i] && !(&cnt_q[i])) cnt_q[i] <= cnt_q[i] + {{(Width-1){1'b0}}, 1'b1};
        end
    end
    assign hit_o  = cnt_q[0];
    assign miss_o = cnt_q[1];
    assign wb_o   = cnt_q[2];
endmodule

// File: rtl/axi_llc_evict_sequencer.sv
// axi_llc_evict_sequencer: one-in-flight lookup -> eviction box -> write-back/refill -> response sequencer; ports clk_i, rst_i (async, active-high) and bus (master modport); perf counters enabled by AXI_LLC_EVICT_SEQ_PERF_EN.
module axi_llc_evict_sequencer
    import axi_llc_evict_sequencer_pkg::*;
#(
    parameter int unsigned SetAssociativity = SA_DEF,
    parameter int unsigned IndexLength      = IL_DEF,
    parameter int unsigned TagLength        = TL_DEF,
    parameter int unsigned PerfCntWidth     = PCW_DEF
) (
    input logic clk_i,
    input logic rst_i,
    axi_llc_evict_sequencer_if.master bus
);
    // The descriptor struct lives in the package at fixed widths.
    if (SetAssociativity != SA_DEF || IndexLength != IL_DEF || TagLength != TL_DEF) begin : g_cfg_err
        $error("axi_llc_evict_sequencer: geometry must match package widths");
    end
    evict_seq_state_e state_q, state_d;
    evict_seq_desc_t  desc_q;
    logic [TagLength-1:0] victim_tag;
    // One-hot way mux over the stored tags of the set.
    always_comb begin
        victim_tag = '0;
        for (int w = 0; w < SetAssociativity; w++)
            victim_tag = victim_tag | (desc_q.old_tags[w*TagLength +: TagLength] & {TagLength{desc_q.way[w]}});
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            desc_q <= '0;
        end else if (state_q == IDLE && bus.lu_valid_i) begin
            desc_q <= '{index: bus.lu_index_i, tag: bus.lu_tag_i, old_tags: bus.lu_old_tag_i,
                        way: bus.lu_hit_way_i, hit: bus.lu_hit_i};
        end else if (state_q == EV_WAIT && bus.box_valid_i) begin
            desc_q.way <= (SetAssociativity == 1) ? '1 : bus.box_way_i;
        end
    end
    always_comb begin
        state_d         = state_q;
        bus.lu_ready_o  = state_q == IDLE;
        bus.hit_o       = state_q == HIT_UPD;
        bus.evict_o     = state_q == EV_WAIT;
        bus.wb_valid_o  = state_q == WB_REQ;
        bus.rf_valid_o  = state_q == RF_REQ;
        bus.rsp_valid_o = state_q == RSP;
        bus.res_ind_o   = (state_q == HIT_UPD) ? desc_q.way : '0;
        case (state_q)
            IDLE:    if (bus.lu_valid_i)     state_d = bus.lu_hit_i ? HIT_UPD : EV_WAIT;
            HIT_UPD: if (bus.box_plru_vld_i) state_d = RSP;
            EV_WAIT: if (bus.box_valid_i)    state_d = bus.box_evict_i ? WB_REQ : RF_REQ;
            WB_REQ:  if (bus.wb_ready_i)     state_d = RF_REQ;
            RF_REQ:  if (bus.rf_ready_i)     state_d = RSP;
            RSP:     if (bus.rsp_ready_i)    state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end
    assign bus.index_o    = desc_q.index;
    assign bus.wb_index_o = desc_q.index;
    assign bus.wb_tag_o   = victim_tag;
    assign bus.wb_way_o   = desc_q.way;
    assign bus.rf_index_o = desc_q.index;
    assign bus.rf_tag_o   = desc_q.tag;
    assign bus.rf_way_o   = desc_q.way;
    assign bus.rsp_way_o  = desc_q.way;
    assign bus.rsp_hit_o  = desc_q.hit;
`ifdef AXI_LLC_EVICT_SEQ_PERF_EN
    axi_llc_evict_seq_perf #(.Width(PerfCntWidth)) u_perf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_hit_i  (state_q == HIT_UPD && bus.box_plru_vld_i),
        .inc_miss_i (state_q == EV_WAIT && bus.box_valid_i),
        .inc_wb_i   (state_q == WB_REQ && bus.wb_ready_i),
        .hit_o      (bus.perf_hit_o),
        .miss_o     (bus.perf_miss_o),
        .wb_o       (bus.perf_wb_o)
    );
`else
    assign bus.perf_hit_o  = {PerfCntWidth{1'b0}};
    assign bus.perf_miss_o = {PerfCntWidth{1'b0}};
    assign bus.perf_wb_o   = {PerfCntWidth{1'b0}};
`endif
    a_box_way_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.box_valid_i |-> $onehot0(bus.box_way_i));
    a_wb_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.wb_valid_o && !bus.wb_ready_i |=> bus.wb_valid_o && $stable({bus.wb_index_o, bus.wb_tag_o, bus.wb_way_o}));
    a_rf_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.rf_valid_o && !bus.rf_ready_i |=> bus.rf_valid_o && $stable({bus.rf_index_o, bus.rf_tag_o, bus.rf_way_o}));
endmodule
